// File: rtl/ng_instr_decoder.sv
// nandgame-core instruction decoder: registered output stage, one-entry skid.
// Optional reserved-bit check and illegal counter: define NG_DECODE_ILLEGAL_EN.
module ng_instr_decoder #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [DATA_W-1:0] instr,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic              is_const,
  output logic [DATA_W-1:0] const_val,
  output logic [2:0]        alu_opcode,
  output logic              alu_zx,
  output logic              alu_sw,
  output logic              use_mem,
  output logic              dst_a,
  output logic              dst_d,
  output logic              dst_m,
  output logic              jmp_lt,
  output logic              jmp_eq,
  output logic              jmp_gt,
`ifdef NG_DECODE_ILLEGAL_EN
  output logic              illegal,
  output logic [CNT_W-1:0]  illegal_cnt,
`endif
  output logic [CNT_W-1:0]  instr_cnt,
  output logic [CNT_W-1:0]  const_cnt
);

  typedef struct packed {
    logic              is_const;
    logic [DATA_W-1:0] const_val;
    logic [2:0]        opcode;
    logic              zx;
    logic              sw;
    logic              use_mem;
    logic              dst_a;
    logic              dst_d;
    logic              dst_m;
    logic              jlt;
    logic              jeq;
    logic              jgt;
`ifdef NG_DECODE_ILLEGAL_EN
    logic              illegal;
`endif
  } bundle_t;

  bundle_t    w_dec;
  bundle_t    w_out;
  bundle_t    r_out;
  bundle_t    r_skid;
  logic       r_out_v;
  logic       r_skid_v;
  logic       w_acc;
  logic       w_dlv;
  logic [CNT_W-1:0] r_icnt;
  logic [CNT_W-1:0] r_ccnt;
`ifdef NG_DECODE_ILLEGAL_EN
  logic [CNT_W-1:0] r_lcnt;
`else
  logic       w_unused_rsvd;
  assign w_unused_rsvd = ^{instr[14:13], instr[11]};
`endif

  assign instr_ready = !r_skid_v && !rst;
  assign w_acc       = instr_valid && instr_ready;
  assign w_dlv       = r_out_v && dec_ready;

  // Field decode of the incoming word; constants only write A.
  always_comb begin
    w_dec = '0;
    if (!instr[15]) begin
      w_dec.is_const  = 1'b1;
      w_dec.const_val = instr;
      w_dec.dst_a     = 1'b1;
    end else begin
      w_dec.opcode  = instr[10:8];
      w_dec.zx      = instr[7];
      w_dec.sw      = instr[6];
      w_dec.use_mem = instr[12];
      w_dec.dst_a   = instr[5];
      w_dec.dst_d   = instr[4];
      w_dec.dst_m   = instr[3];
      w_dec.jlt     = instr[2];
      w_dec.jeq     = instr[1];
      w_dec.jgt     = instr[0];
`ifdef NG_DECODE_ILLEGAL_EN
      w_dec.illegal = instr[14] | instr[13] | instr[11];
      if (w_dec.illegal) begin
        w_dec.dst_a = 1'b0;
        w_dec.dst_d = 1'b0;
        w_dec.dst_m = 1'b0;
        w_dec.jlt   = 1'b0;
        w_dec.jeq   = 1'b0;
        w_dec.jgt   = 1'b0;
      end
`endif
    end
  end

  // Output register and skid: refill output from skid first, else from input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out    <= '0;
      r_skid   <= '0;
      r_out_v  <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (w_dlv) begin
      if (r_skid_v) begin
        r_out    <= r_skid;
        r_skid_v <= 1'b0;
      end else if (w_acc) begin
        r_out <= w_dec;
      end else begin
        r_out_v <= 1'b0;
      end
    end else if (!r_out_v) begin
      if (w_acc) begin
        r_out   <= w_dec;
        r_out_v <= 1'b1;
      end
    end else if (w_acc) begin
      r_skid   <= w_dec;
      r_skid_v <= 1'b1;
    end
  end

  // Saturating delivery statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_icnt <= '0;
      r_ccnt <= '0;
    end else if (w_dlv) begin
      if (r_icnt != '1)
        r_icnt <= r_icnt + CNT_W'(1);
      if (r_out.is_const && r_ccnt != '1)
        r_ccnt <= r_ccnt + CNT_W'(1);
    end
  end

`ifdef NG_DECODE_ILLEGAL_EN
  // Saturating count of delivered illegal bundles.
  always_ff @(posedge clk) begin
    if (rst)
      r_lcnt <= '0;
    else if (w_dlv && r_out.illegal && r_lcnt != '1)
      r_lcnt <= r_lcnt + CNT_W'(1);
  end

  assign illegal     = w_out.illegal;
  assign illegal_cnt = r_lcnt;
`endif

  assign w_out      = rst ? '0 : r_out;
  assign dec_valid  = r_out_v && !rst;
  assign is_const   = w_out.is_const;
  assign const_val  = w_out.const_val;
  assign alu_opcode = w_out.opcode;
  assign alu_zx     = w_out.zx;
  assign alu_sw     = w_out.sw;
  assign use_mem    = w_out.use_mem;
  assign dst_a      = w_out.dst_a;
  assign dst_d      = w_out.dst_d;
  assign dst_m      = w_out.dst_m;
  assign jmp_lt     = w_out.jlt;
  assign jmp_eq     = w_out.jeq;
  assign jmp_gt     = w_out.jgt;
  assign instr_cnt  = r_icnt;
  assign const_cnt  = r_ccnt;

endmodule

// File: tb/tb_ng_instr_decoder.sv
// Scoreboard bench for ng_instr_decoder (CNT_W=4 to reach saturation).
// Works with or without NG_DECODE_ILLEGAL_EN.
module tb_ng_instr_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b1;
  logic        is_const;
  logic [15:0] const_val;
  logic [2:0]  alu_opcode;
  logic        alu_zx, alu_sw, use_mem;
  logic        dst_a, dst_d, dst_m;
  logic        jmp_lt, jmp_eq, jmp_gt;
  logic [3:0]  instr_cnt, const_cnt;
  logic        ill_b;
`ifdef NG_DECODE_ILLEGAL_EN
  logic        illegal;
  logic [3:0]  illegal_cnt;
  assign ill_b = illegal;
`else
  assign ill_b = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  logic [29:0] q[$];

  ng_instr_decoder #(.DATA_W(16), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .is_const(is_const), .const_val(const_val),
    .alu_opcode(alu_opcode), .alu_zx(alu_zx), .alu_sw(alu_sw),
    .use_mem(use_mem), .dst_a(dst_a), .dst_d(dst_d), .dst_m(dst_m),
    .jmp_lt(jmp_lt), .jmp_eq(jmp_eq), .jmp_gt(jmp_gt),
`ifdef NG_DECODE_ILLEGAL_EN
    .illegal(illegal), .illegal_cnt(illegal_cnt),
`endif
    .instr_cnt(instr_cnt), .const_cnt(const_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [29:0] ec(input logic [15:0] v);
    return {1'b1, v, 3'b000, 1'b0, 1'b0, 1'b0, 3'b100, 3'b000, 1'b0};
  endfunction

  function automatic logic [29:0] ex(input logic [2:0] opc, input logic zx,
                                     input logic sw, input logic mem,
                                     input logic [2:0] dst, input logic [2:0] jmp,
                                     input logic ill);
    return {1'b0, 16'h0000, opc, zx, sw, mem, dst, jmp, ill};
  endfunction

  function automatic logic [29:0] act();
    return {is_const, const_val, alu_opcode, alu_zx, alu_sw, use_mem,
            dst_a, dst_d, dst_m, jmp_lt, jmp_eq, jmp_gt, ill_b};
  endfunction

  task automatic chk(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, a, e);
    end
  endtask

  // Monitor: every delivered bundle must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && dec_valid && dec_ready) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL bundle_unexpected actual=%h required=none", act());
      end else begin
        logic [29:0] e;
        e = q.pop_front();
        if (act() !== e) begin
          failures++;
          $display("FAIL bundle actual=%h required=%h", act(), e);
        end
      end
    end
  end

  task automatic send(input logic [15:0] w, input logic [29:0] e, input bit trk);
    bit ok;
    ok = 1'b0;
    instr = w;
    instr_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (instr_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=0 required=1");
    end else if (trk) begin
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0", q.size());
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", int'(instr_ready), 0);
    chk("rst_valid", int'(dec_valid), 0);
    chk("rst_fields", int'(act() != 0), 0);
    chk("rst_icnt", int'(instr_cnt), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", int'(instr_ready), 1);
    @(posedge clk);
    #1;

    send(16'h0005, ec(16'h0005), 1'b1);
    chk("latency_valid", int'(dec_valid), 1);
    drain();
    chk("icnt_1", int'(instr_cnt), 1);
    chk("ccnt_1", int'(const_cnt), 1);

    send(16'h8410, ex(3'b100, 0, 0, 0, 3'b010, 3'b000, 0), 1'b1);
`ifdef NG_DECODE_ILLEGAL_EN
    send(16'h9C8F, ex(3'b100, 1, 0, 1, 3'b000, 3'b000, 1), 1'b1);
    send(16'hE018, ex(3'b000, 0, 0, 0, 3'b000, 3'b000, 1), 1'b1);
`else
    send(16'h9C8F, ex(3'b100, 1, 0, 1, 3'b001, 3'b111, 0), 1'b1);
    send(16'hE018, ex(3'b000, 0, 0, 0, 3'b011, 3'b000, 0), 1'b1);
`endif
    drain();
    chk("icnt_4", int'(instr_cnt), 4);
    chk("ccnt_1b", int'(const_cnt), 1);
`ifdef NG_DECODE_ILLEGAL_EN
    chk("lcnt_2", int'(illegal_cnt), 2);
`endif

    dec_ready = 1'b0;
    send(16'h0001, ec(16'h0001), 1'b1);
    send(16'h0002, ec(16'h0002), 1'b1);
    instr = 16'h0003;
    instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_ready", int'(instr_ready), 0);
      chk("held_valid", int'(dec_valid), 1);
      chk("held_const", int'(const_val), 1);
    end
    @(posedge clk);
    #1;
    dec_ready = 1'b1;
    send(16'h0003, ec(16'h0003), 1'b1);
    drain();
    chk("icnt_7", int'(instr_cnt), 7);
    chk("ccnt_4", int'(const_cnt), 4);

    for (int i = 0; i < 20; i++)
      send(16'h0010 + 16'(i), ec(16'h0010 + 16'(i)), 1'b1);
    drain();
    chk("icnt_sat", int'(instr_cnt), 15);
    chk("ccnt_sat", int'(const_cnt), 15);
    send(16'h8410, ex(3'b100, 0, 0, 0, 3'b010, 3'b000, 0), 1'b1);
    drain();
    chk("icnt_hold", int'(instr_cnt), 15);
    chk("ccnt_hold", int'(const_cnt), 15);
`ifdef NG_DECODE_ILLEGAL_EN
    chk("lcnt_hold", int'(illegal_cnt), 2);
`endif

    dec_ready = 1'b0;
    send(16'h0020, '0, 1'b0);
    send(16'h0021, '0, 1'b0);
    @(negedge clk);
    chk("two_held_ready", int'(instr_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", int'(instr_ready), 0);
    chk("mid_rst_valid", int'(dec_valid), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", int'(instr_ready), 1);
    chk("post_rst_valid", int'(dec_valid), 0);
    chk("post_rst_icnt", int'(instr_cnt), 0);
    chk("post_rst_ccnt", int'(const_cnt), 0);
`ifdef NG_DECODE_ILLEGAL_EN
    chk("post_rst_lcnt", int'(illegal_cnt), 0);
`endif
    @(posedge clk);
    #1;
    dec_ready = 1'b1;
    send(16'h0007, ec(16'h0007), 1'b1);
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("after_rst_icnt", int'(instr_cnt), 1);
    chk("after_rst_ccnt", int'(const_cnt), 1);
    chk("queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ng_instr_decoder.md
Name: ng_instr_decoder

Overview:
- Decodes 16-bit nandgame-core instruction words into the control fields consumed by the core ALU: opcode, zx, sw. Also produces operand-source, destination and jump-condition fields.
- Sits between instruction fetch and execute.
- Uses a valid/ready stream on both sides, a registered output stage and a one-entry skid buffer, so fetch can run at full rate while execute backpressures.
- Keeps saturating statistics counters.

Parameters:
- DATA_W, 16, instruction and constant width; fixed at 16 for the field map below.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  input  1  core clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- instr_valid  input  1  upstream word valid
- instr_ready  output  1  decoder can accept a word
- instr  input  DATA_W  instruction word
- dec_valid  output  1  decoded bundle valid
- dec_ready  input  1  execute accepts bundle
- is_const  output  1  1 = A-constant instruction (instr[15]=0)
- const_val  output  DATA_W  constant value; 0 for compute instructions
- alu_opcode  output  3  {u, op1, op0} = instr[10:8]
- alu_zx  output  1  instr[7]
- alu_sw  output  1  instr[6]
- use_mem  output  1  instr[12]: Y operand is *A rather than A
- dst_a  output  1  write A
- dst_d  output  1  write D
- dst_m  output  1  write *A
- jmp_lt  output  1  jump if result < 0
- jmp_eq  output  1  jump if result = 0
- jmp_gt  output  1  jump if result > 0
- instr_cnt  output  CNT_W  bundles delivered downstream (saturating)
- const_cnt  output  CNT_W  constant bundles delivered (saturating)

Behaviour:
- Reset:
  - rst high on a clock edge clears the output register, the skid register and both counters.
  - dec_valid=0, every decoded output=0, instr_ready=0 while rst=1.
  - instr_ready=1 on the first cycle after rst deasserts.
  - Reset mid-transfer discards any held bundles. There is no partial completion.
- Decode (combinational from instr, captured at acceptance):
  - instr[15]=0: is_const=1, const_val=instr, dst_a=1. All other fields are 0.
  - instr[15]=1: is_const=0, const_val=0, alu_opcode=instr[10:8], alu_zx=instr[7], alu_sw=instr[6], use_mem=instr[12], dst_a=instr[5], dst_d=instr[4], dst_m=instr[3], jmp_lt=instr[2], jmp_eq=instr[1], jmp_gt=instr[0].
  - instr[14:13] and instr[11] are ignored unless the optional feature is enabled.
- Handshake:
  - Acceptance = instr_valid & instr_ready. Delivery = dec_valid & dec_ready.
  - Latency is 1 cycle: a word accepted at edge N appears on the outputs after edge N, when the output register was empty or was delivered at edge N.
  - instr_ready = !skid_full & !rst. It is registered-state based and never combinational from dec_ready.
  - If the word is accepted while the output register is full and not delivered, the bundle goes to the skid register.
  - When the output register is delivered and the skid register is full, skid moves to output on that edge. A simultaneous new acceptance is impossible because instr_ready=0.
  - Order is strictly preserved. Output fields are held stable while dec_valid=1 and dec_ready=0.
  - Full: 2 bundles held, instr_ready=0. Empty: dec_valid=0, outputs retain their last values (don't-care).
- Counters:
  - instr_cnt increments by 1 on each delivery. const_cnt increments when the delivered bundle has is_const=1.
  - Both saturate at 2^CNT_W-1 and never wrap.

Optional Feature:
- Macro: NG_DECODE_ILLEGAL_EN.
- Defined:
  - Adds output illegal (1 bit), which travels with the bundle.
  - illegal=1 when instr[15]=1 and any of instr[14], instr[13], instr[11] is 1.
  - An illegal bundle forces dst_a=dst_d=dst_m=0 and all jmp_* = 0. Other fields decode normally.
  - Adds output illegal_cnt (CNT_W, saturating), which counts delivered illegal bundles. It is cleared by rst.
- Undefined: no illegal port and no illegal_cnt; reserved bits are ignored.

Test Plan:
- Reset then instr=0x0005, valid 1 cycle, dec_ready=1 -> next cycle dec_valid=1, is_const=1, const_val=0x0005, dst_a=1, others 0; instr_cnt=1, const_cnt=1.
- instr=0x8410 (D=D+A) -> alu_opcode=3'b100, alu_zx=0, alu_sw=0, use_mem=0, dst_d=1, dst_a=0, jmp_*=0, const_val=0.
- instr=0x9C8F -> alu_opcode=3'b100, alu_zx=1, alu_sw=0, use_mem=1, dst_a=0, dst_d=0, dst_m=1, jmp_lt=jmp_eq=jmp_gt=1.
- dec_ready=0, back-to-back 0x0001,0x0002,0x0003 offered -> first two accepted, instr_ready=0 on the third. Raise dec_ready -> outputs 0x0001,0x0002,0x0003 on consecutive cycles in order, no loss or duplication.
- CNT_W=4, deliver 20 constants -> instr_cnt=const_cnt=15 and both hold. Assert rst with 2 bundles held -> next cycle dec_valid=0, counters=0, instr_ready=0 during rst and 1 after.
- NG_DECODE_ILLEGAL_EN defined, instr=0xE018 -> illegal=1, dst_d=0, dst_m=0, illegal_cnt=1. Undefined -> same word decodes dst_d=1, dst_m=1.
